lp_booth_r4_mult: RTL and testbench

LP_BOOTH_R4_MULT -- requirements
Module: lp_booth_r4_mult

---
 rtl/lp_booth_pkg.sv | 14 +
 rtl/booth_r4_encoder.sv | 14 +
 rtl/lp_booth_r4_mult.sv | 124 ++++++++++++
 tb/tb_lp_booth_r4_mult.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lp_booth_pkg.sv
// lp_booth_pkg: shared types and constants for the low-power radix-4 Booth multiplier.
package lp_booth_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    typedef enum logic [2:0] {D_ZERO, D_P1, D_P2, D_M1, D_M2} booth_digit_t;
    localparam logic [1:0] PM_NORMAL = 2'b00;
    localparam logic [1:0] PM_LOW    = 2'b01;
    localparam logic [1:0] PM_ULTRA  = 2'b10;
    localparam logic [1:0] EW_ZERO = 2'd1;
    localparam logic [1:0] EW_ONE  = 2'd2;
    localparam logic [1:0] EW_TWO  = 2'd3;
    function automatic logic [1:0] digit_weight(booth_digit_t d);
        return d == D_ZERO ? EW_ZERO : (d == D_P1 || d == D_M1) ? EW_ONE : EW_TWO;
    endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a Booth triple {b[2i+1], b[2i], b[2i-1]} to a radix-4 digit.
module booth_r4_encoder
    import lp_booth_pkg::*;
(
    input  logic [2:0]   triple_i,
    output booth_digit_t digit_o
);
    always_comb begin
        digit_o = (triple_i == 3'b001 || triple_i == 3'b010) ? D_P1 :
                  (triple_i == 3'b011) ? D_P2 :
                  (triple_i == 3'b100) ? D_M2 :
                  (triple_i == 3'b101 || triple_i == 3'b110) ? D_M1 : D_ZERO;
    end
endmodule

// File: rtl/lp_booth_r4_mult.sv
// lp_booth_r4_mult: sequential radix-4 Booth multiplier, one digit per cycle,
// with early termination and accumulator write suppression in the low-power modes.
module lp_booth_r4_mult
    import lp_booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EN_W  = 12
) (
    input  logic               gated_clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               signed_mode,
    input  logic [1:0]         power_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [5:0]         cycles,
    output logic [EN_W-1:0]    energy,
    output logic               busy
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int XW   = WIDTH + 2;
    localparam int PW   = 2 * WIDTH;

    state_t            state_q, state_d;
    logic [XW-1:0]     a_q, b_q;
    logic [1:0]        mode_q;
    logic [PW-1:0]     acc_q, acc_d, product_q;
    logic [5:0]        cnt_q, cnt_d, cycles_q;
    logic [EN_W-1:0]   en_q, en_d, energy_q;
    logic [XW:0]       b_pad;
    booth_digit_t      digits [ITER];
    booth_digit_t      cur;
    logic              rest_zero, last, acc_we;
    logic [PW-1:0]     a_w, a_sh, pp_mag, pp;
    logic [EN_W:0]     en_sum;

    assign b_pad = {b_q, 1'b0};

    for (genvar i = 0; i < ITER; i++) begin : g_enc
        booth_r4_encoder u_enc (.triple_i(b_pad[2*i+2 -: 3]), .digit_o(digits[i]));
    end

    // Current digit plus a look-ahead: are all later digits zero?
    always_comb begin
        cur = D_ZERO;
        rest_zero = 1'b1;
        for (int j = 0; j < ITER; j++) begin
            if (cnt_q == 6'(j)) cur = digits[j];
            if (6'(j) > cnt_q && digits[j] != D_ZERO) rest_zero = 1'b0;
        end
    end

    always_comb begin
        last   = mode_q == PM_NORMAL ? cnt_q == 6'(ITER - 1) : rest_zero;
        acc_we = !(mode_q == PM_ULTRA && cur == D_ZERO);
        a_w    = {{(PW-XW){a_q[XW-1]}}, a_q};
        a_sh   = a_w << {cnt_q, 1'b0};
        pp_mag = (cur == D_P2 || cur == D_M2) ? a_sh << 1 : a_sh;
        pp     = cur == D_ZERO ? '0 : (cur == D_M1 || cur == D_M2) ? -pp_mag : pp_mag;
        acc_d  = acc_q + pp;
        cnt_d  = cnt_q + 6'd1;
        en_sum = {1'b0, en_q} + {{(EN_W-1){1'b0}}, digit_weight(cur)};
        en_d   = en_sum[EN_W] ? '1 : en_sum[EN_W-1:0];
    end

    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = COMPUTE;
            COMPUTE: if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        busy      = state_q == COMPUTE;
        out_valid = state_q == DONE;
    end

    always_ff @(posedge gated_clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= PM_NORMAL;
            acc_q     <= '0;
            cnt_q     <= '0;
            en_q      <= '0;
            product_q <= '0;
            cycles_q  <= '0;
            energy_q  <= '0;
        end else if (in_valid && in_ready) begin
            a_q    <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
            b_q    <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
            mode_q <= power_mode == 2'b11 ? PM_NORMAL : power_mode;
            acc_q  <= '0;
            cnt_q  <= '0;
            en_q   <= '0;
        end else if (state_q == COMPUTE) begin
            if (acc_we) acc_q <= acc_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
            if (last) begin
                product_q <= acc_d;
                cycles_q  <= cnt_d;
                energy_q  <= en_d;
            end
        end
    end

    assign product = product_q;
    assign cycles  = cycles_q;
    assign energy  = energy_q;
endmodule

// File: tb/tb_lp_booth_r4_mult.sv
// tb_lp_booth_r4_mult: directed vectors with hand-computed results, checked by a
// scoreboard monitor that pops an expectation on every output handshake.
module tb_lp_booth_r4_mult;
    logic        gated_clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        signed_mode = 1'b0;
    logic [1:0]  power_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic [5:0]  cycles;
    logic [11:0] energy;
    logic        busy;

    typedef struct {
        logic [15:0] p;
        logic [5:0]  c;
        logic [11:0] e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    lp_booth_r4_mult #(.WIDTH(8), .EN_W(12)) dut (
        .gated_clk(gated_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier), .signed_mode(signed_mode),
        .power_mode(power_mode), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .cycles(cycles), .energy(energy), .busy(busy)
    );

    always #5 gated_clk = ~gated_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge gated_clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got product %0h expected none", product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {16'h0, product}, {16'h0, e.p});
                chk("cycles", {26'h0, cycles}, {26'h0, e.c});
                chk("energy", {20'h0, energy}, {20'h0, e.e});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [1:0] m,
                        input bit push, input logic [15:0] p, input logic [5:0] c, input logic [11:0] e);
        int n = 0;
        @(negedge gated_clk);
        while (!in_ready && n < 100) begin
            @(negedge gated_clk);
            n++;
        end
        chk("in_ready_wait", {31'h0, in_ready}, 32'h1);
        multiplicand = a;
        multiplier = b;
        signed_mode = s;
        power_mode = m;
        in_valid = 1'b1;
        if (push) sb.push_back('{p: p, c: c, e: e});
        @(negedge gated_clk);
        in_valid = 1'b0;
        multiplicand = 8'hA5;
        multiplier = 8'h5A;
        signed_mode = ~s;
        power_mode = ~m;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge gated_clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [1:0] m,
                       input logic [15:0] p, input logic [5:0] c, input logic [11:0] e);
        send(a, b, s, m, 1'b1, p, c, e);
        drain();
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_product", {16'h0, product}, 32'h0);
        chk("rst_cycles", {26'h0, cycles}, 32'h0);
        chk("rst_energy", {20'h0, energy}, 32'h0);
    endtask

    initial begin
        int n;
        #1;
        chk_reset_state();
        @(negedge gated_clk);
        reset = 1'b0;

        run(8'd5,   8'd3,   1'b1, 2'b00, 16'd15,    6'd5, 12'd7);
        run(8'hFB,  8'hFD,  1'b1, 2'b01, 16'd15,    6'd2, 12'd4);
        run(8'hFF,  8'hFF,  1'b0, 2'b00, 16'd65025, 6'd5, 12'd7);
        run(8'hFF,  8'hFF,  1'b1, 2'b00, 16'd1,     6'd5, 12'd6);
        run(8'h80,  8'h80,  1'b1, 2'b00, 16'd16384, 6'd5, 12'd7);
        run(8'h7F,  8'h00,  1'b0, 2'b10, 16'd0,     6'd1, 12'd1);
        run(8'd200, 8'd100, 1'b0, 2'b01, 16'h4E20,  6'd4, 12'd9);
        run(8'd2,   8'd3,   1'b0, 2'b11, 16'd6,     6'd5, 12'd7);

        // Hold the result in DONE while a new request waits
        out_ready = 1'b0;
        send(8'd3, 8'd4, 1'b1, 2'b10, 1'b1, 16'd12, 6'd2, 12'd3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge gated_clk);
            n++;
        end
        multiplicand = 8'd9;
        multiplier = 8'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge gated_clk);
            chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
            chk("hold_busy", {31'h0, busy}, 32'h0);
            chk("hold_product", {16'h0, product}, 32'd12);
            chk("hold_cycles", {26'h0, cycles}, 32'd2);
            chk("hold_energy", {20'h0, energy}, 32'd3);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge gated_clk);
        chk("post_hold_busy", {31'h0, busy}, 32'h0);
        chk("post_hold_in_ready", {31'h0, in_ready}, 32'h1);
        chk("idle_keeps_product", {16'h0, product}, 32'd12);

        // Abort an operation with reset during its third compute edge
        send(8'd100, 8'd3, 1'b1, 2'b00, 1'b0, 16'd0, 6'd0, 12'd0);
        @(negedge gated_clk);
        @(negedge gated_clk);
        reset = 1'b1;
        #1;
        chk_reset_state();
        @(negedge gated_clk);
        reset = 1'b0;
        #1;
        chk_reset_state();
        run(8'd7, 8'hFE, 1'b1, 2'b00, 16'hFFF2, 6'd5, 12'd7);

        repeat (3) @(negedge gated_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
